// File: rtl/lz4_pkg.sv
// rtl/lz4_pkg.sv - shared constants and state encoding for the LZ4 match-copy engine
package lz4_pkg;

    localparam int LZ4_WIN_AW    = 16;
    localparam int LZ4_LEN_W     = 16;
    localparam int LZ4_MIN_MATCH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COPY  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERR   = 2'd3
    } lz4_state_t;

endpackage

// File: rtl/hist_ram_64Kx8.sv
// rtl/hist_ram_64Kx8.sv - simple dual-port byte RAM, 1-cycle synchronous read, read-first
module hist_ram_64Kx8 #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [2**ADDR_W];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lz4_match_copy.sv
// rtl/lz4_match_copy.sv - rebuilds the LZ4 byte stream from literal/match commands over a history window
module lz4_match_copy
    import lz4_pkg::*;
#(
    parameter int ADDR_W = LZ4_WIN_AW,
    parameter int LEN_W  = LZ4_LEN_W
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              hist_clean,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_is_match,
    input  logic [7:0]        cmd_lit,
    input  logic [ADDR_W-1:0] cmd_offset,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [7:0]        dout_byte,
    output logic              dout_valid,
    output logic              dec_busy,
    output logic              dec_err
);

    lz4_state_t        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] hist_cnt_q, hist_cnt_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic [7:0]        last_q, last_d;
    logic              lit_vld_q, lit_vld_d;
    logic              rd_pend_q, rd_pend_d;
    logic              dec_err_q, dec_err_d;
    logic              fwd_hit_q, fwd_hit_d;
    logic [7:0]        fwd_data_q, fwd_data_d;

    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [7:0]        ram_wdata, ram_rdata;
    logic [7:0]        copy_byte;
    logic              cnt_inc;
    logic              bad_match;

    hist_ram_64Kx8 #(.ADDR_W(ADDR_W)) u_hist (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // A read that hit the address written in the same cycle sees the new byte, not stale RAM.
    assign copy_byte = fwd_hit_q ? fwd_data_q : ram_rdata;

    assign bad_match = (cmd_offset == '0) || (cmd_offset > hist_cnt_q) || (cmd_len == '0);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        hist_cnt_d = hist_cnt_q;
        remain_d   = remain_q;
        last_d     = last_q;
        lit_vld_d  = 1'b0;
        rd_pend_d  = 1'b0;
        dec_err_d  = dec_err_q;
        ram_we     = 1'b0;
        ram_waddr  = wr_ptr_q;
        ram_wdata  = copy_byte;
        ram_re     = 1'b0;
        ram_raddr  = rd_ptr_q;
        cmd_ready  = 1'b0;
        cnt_inc    = 1'b0;

        // Byte read in the previous cycle is committed to history and emitted now.
        if (rd_pend_q) begin
            ram_we  = 1'b1;
            last_d  = copy_byte;
            cnt_inc = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                cmd_ready = !hist_clean;
                if (hist_clean) begin
                    wr_ptr_d   = '0;
                    hist_cnt_d = '0;
                    dec_err_d  = 1'b0;
                end else if (cmd_valid) begin
                    if (!cmd_is_match) begin
                        ram_we    = 1'b1;
                        ram_wdata = cmd_lit;
                        last_d    = cmd_lit;
                        lit_vld_d = 1'b1;
                        cnt_inc   = 1'b1;
                    end else if (bad_match) begin
                        dec_err_d = 1'b1;
                        state_d   = ST_ERR;
                    end else begin
                        rd_ptr_d = wr_ptr_q - cmd_offset;
                        remain_d = cmd_len;
                        state_d  = ST_COPY;
                    end
                end
            end
            ST_COPY: begin
                ram_re    = 1'b1;
                rd_pend_d = 1'b1;
                rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
                if (remain_q != '0) begin
                    remain_d = remain_q - LEN_W'(1);
                end
                if (remain_q <= LEN_W'(1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                if (hist_clean) begin
                    wr_ptr_d   = '0;
                    hist_cnt_d = '0;
                    dec_err_d  = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cnt_inc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (hist_cnt_q != '1) begin
                hist_cnt_d = hist_cnt_q + ADDR_W'(1);
            end
        end
    end

    assign fwd_hit_d  = ram_we && ram_re && (ram_waddr == ram_raddr);
    assign fwd_data_d = ram_wdata;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            hist_cnt_q <= '0;
            remain_q   <= '0;
            last_q     <= '0;
            lit_vld_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            dec_err_q  <= 1'b0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            hist_cnt_q <= hist_cnt_d;
            remain_q   <= remain_d;
            last_q     <= last_d;
            lit_vld_q  <= lit_vld_d;
            rd_pend_q  <= rd_pend_d;
            dec_err_q  <= dec_err_d;
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign dout_valid = lit_vld_q || rd_pend_q;
    assign dout_byte  = rd_pend_q ? copy_byte : last_q;
    assign dec_busy   = (state_q == ST_COPY) || (state_q == ST_DRAIN);
    assign dec_err    = dec_err_q;

endmodule

// File: tb/tb_lz4_match_copy.sv
// tb/tb_lz4_match_copy.sv - directed self-checking bench for lz4_match_copy
module tb_lz4_match_copy;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        hist_clean = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_is_match = 1'b0;
    logic [7:0]  cmd_lit = 8'h00;
    logic [15:0] cmd_offset = 16'h0;
    logic [15:0] cmd_len = 16'h0;
    logic [7:0]  dout_byte;
    logic        dout_valid;
    logic        dec_busy;
    logic        dec_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] expq [$];

    always #5 clk = ~clk;

    lz4_match_copy dut (
        .clk          (clk),
        .rstN         (rstN),
        .hist_clean   (hist_clean),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_is_match (cmd_is_match),
        .cmd_lit      (cmd_lit),
        .cmd_offset   (cmd_offset),
        .cmd_len      (cmd_len),
        .dout_byte    (dout_byte),
        .dout_valid   (dout_valid),
        .dec_busy     (dec_busy),
        .dec_err      (dec_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_lit(input logic [7:0] b, input bit check);
        cmd_valid    = 1'b1;
        cmd_is_match = 1'b0;
        cmd_lit      = b;
        tick();
        cmd_valid = 1'b0;
        if (check) begin
            chk("lit_valid", dout_valid, 1);
            chk("lit_byte", dout_byte, b);
        end
    endtask

    task automatic clean();
        hist_clean = 1'b1;
        #1;
        chk("ready_low_during_clean", cmd_ready, 0);
        tick();
        hist_clean = 1'b0;
        #1;
        chk("err_after_clean", dec_err, 0);
        chk("ready_after_clean", cmd_ready, 1);
    endtask

    task automatic send_match(input logic [15:0] off, input logic [15:0] len);
        cmd_valid    = 1'b1;
        cmd_is_match = 1'b1;
        cmd_offset   = off;
        cmd_len      = len;
        tick();
        cmd_valid    = 1'b0;
        cmd_is_match = 1'b0;
    endtask

    task automatic do_match(input logic [15:0] off, input logic [15:0] len);
        send_match(off, len);
        chk("m_busy_t1", dec_busy, 1);
        chk("m_nodout_t1", dout_valid, 0);
        chk("m_ready_t1", cmd_ready, 0);
        for (int k = 0; k < int'(len); k++) begin
            tick();
            chk("m_valid", dout_valid, 1);
            chk("m_byte", dout_byte, expq[k]);
            chk("m_busy", dec_busy, 1);
            chk("m_ready_low", cmd_ready, 0);
        end
        tick();
        chk("m_busy_end", dec_busy, 0);
        chk("m_ready_end", cmd_ready, 1);
        chk("m_valid_end", dout_valid, 0);
    endtask

    task automatic err_match(input logic [15:0] off, input logic [15:0] len);
        send_match(off, len);
        chk("e_err", dec_err, 1);
        chk("e_nodout", dout_valid, 0);
        chk("e_ready", cmd_ready, 0);
        tick();
        chk("e_err_sticky", dec_err, 1);
        chk("e_nodout2", dout_valid, 0);
        chk("e_ready2", cmd_ready, 0);
    endtask

    initial begin
        #12;
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout_byte", dout_byte, 0);
        chk("rst_dec_err", dec_err, 0);
        chk("rst_dec_busy", dec_busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        rstN = 1'b1;
        tick();

        send_lit(8'h41, 1'b1);
        send_lit(8'h42, 1'b1);
        send_lit(8'h43, 1'b1);
        tick();
        chk("lit_valid_drop", dout_valid, 0);

        clean();
        send_lit("a", 1'b1); send_lit("b", 1'b1); send_lit("c", 1'b1); send_lit("d", 1'b1);
        expq = '{"a", "b", "c", "d", "a", "b", "c", "d"};
        do_match(16'd4, 16'd8);

        clean();
        send_lit(8'h5A, 1'b1);
        expq = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        do_match(16'd1, 16'd6);

        clean();
        send_lit("x", 1'b1); send_lit("y", 1'b1);
        expq = '{"x", "y", "x", "y", "x"};
        do_match(16'd2, 16'd5);

        clean();
        send_lit("a", 1'b1); send_lit("b", 1'b1); send_lit("c", 1'b1);
        expq = '{"a", "b", "c", "a", "b", "c", "a"};
        do_match(16'd3, 16'd7);

        clean();
        send_lit(8'h01, 1'b1); send_lit(8'h02, 1'b1); send_lit(8'h03, 1'b1);
        err_match(16'd4, 16'd4);
        clean();
        send_lit(8'h11, 1'b1);
        err_match(16'd0, 16'd4);
        clean();
        send_lit(8'h22, 1'b1);
        err_match(16'd1, 16'd0);
        clean();

        cmd_valid    = 1'b1;
        cmd_is_match = 1'b0;
        for (int i = 0; i < 65534; i++) begin
            cmd_lit = i[7:0];
            tick();
        end
        cmd_valid = 1'b0;
        send_lit(8'hEE, 1'b1);
        send_lit(8'hEF, 1'b1);
        send_lit(8'hF0, 1'b1);
        expq = '{8'hEE, 8'hEF, 8'hF0};
        do_match(16'd3, 16'd3);

        send_match(16'd1, 16'd10);
        tick();
        tick();
        chk("pre_rst_busy", dec_busy, 1);
        chk("pre_rst_valid", dout_valid, 1);
        rstN = 1'b0;
        #1;
        chk("midrst_valid", dout_valid, 0);
        chk("midrst_busy", dec_busy, 0);
        #7;
        rstN = 1'b1;
        tick();
        chk("postrst_ready", cmd_ready, 1);
        chk("postrst_err", dec_err, 0);
        err_match(16'd1, 16'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
